quarter_wave_oscillator: RTL
============================

QUARTER_WAVE_OSCILLATOR -- requirements
Module: quarter_wave_oscillator

Interface
REQ-001 The block SHALL have the parameter ACC_WIDTH, default 24, giving the phase accumulator and phase increment width in bits (legal range 8..32).
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit, the reset; it SHALL be asynchronous and active-low.
REQ-004 The block SHALL have the port enable, input, 1 bit; when low, sample_tick SHALL be ignored.
REQ-005 The block SHALL have the port sample_tick, input, 1 bit, a one-cycle sample-rate strobe that requests one output sample.
REQ-006 The block SHALL have the port phase_inc, input, ACC_WIDTH bits, the per-sample phase step (tuning word), unsigned.
REQ-007 The block SHALL have the port phase_sync, input, 1 bit, a synchronous request to restart the phase at zero.
REQ-008 The block SHALL have the port table_phase, output, 6 bits, the quarter-wave table address, registered.
REQ-009 The block SHALL have the port table_data, input, 16 bits, the combinational quarter-wave table output for table_phase (offset binary, positive half only).
REQ-010 The block SHALL have the port sample, output, 16 bits, the full-wave sine sample, registered.
REQ-011 The block SHALL have the port sample_valid, output, 1 bit, high for exactly one cycle when sample is updated.

Function
REQ-012 The block SHALL address the table from the phase p[7:0], the top 8 bits of the accumulator value as held before any update in that cycle.
REQ-013 The block SHALL map the 6-bit address as follows: quadrant p[7:6] of 0 or 2 gives table_phase = p[5:0]; quadrant 1 or 3 gives table_phase = ~p[5:0] (63 - p[5:0]).
REQ-014 The block SHALL register a negate flag, equal to p[7], alongside table_phase.
REQ-015 Stage 1, in the cycle after an accepted tick, SHALL present table_phase and the negate flag from registers.
REQ-016 Stage 2, in the next cycle, SHALL register sample = negate ? (~table_data + 1) mod 2^16 : table_data, and SHALL assert sample_valid.
REQ-017 The latency from an accepted tick to the sample_valid cycle SHALL be 2 clocks.
REQ-018 The pipeline SHALL be fully pipelined: a tick on every cycle SHALL yield a sample on every cycle.
REQ-019 On an accepted tick, the accumulator SHALL update to acc + phase_inc, modulo 2^ACC_WIDTH, wrapping silently with no flag.
REQ-020 phase_sync SHALL take priority over the accumulator value: the sampled phase for that cycle SHALL be 0, and the accumulator SHALL load (tick ? phase_inc : 0).
REQ-021 phase_sync SHALL be honoured regardless of enable.
REQ-022 While enable is low, the accumulator SHALL hold, in-flight stages SHALL complete, and sample SHALL hold its last value.
REQ-023 table_phase SHALL hold its value between ticks.

Reset
REQ-024 On rst_n low, the block SHALL asynchronously clear the accumulator to 0, table_phase to 0, the negate flag to 0, and sample_valid to 0.
REQ-025 On rst_n low, sample SHALL reset to 16'h8000 (16'h0000 when SINE_SIGNED_OUT_EN is defined).
REQ-026 Reset asserted mid-pipeline SHALL discard in-flight samples; no sample_valid pulse SHALL occur for them after release.
REQ-027 The first tick after reset release SHALL be processed normally.

Configuration
REQ-028 With the macro SINE_SIGNED_OUT_EN defined, the block SHALL output sample in two's complement (the offset-binary result with its MSB inverted).
REQ-029 Without SINE_SIGNED_OUT_EN, the block SHALL output sample in offset binary, with midscale 16'h8000.

Verification
REQ-030 Reset, then a tick with acc = 0 -> table_phase = 0 after 1 cycle; sample = 16'h8192 with sample_valid after 2 cycles.
REQ-031 p = 8'h40 -> table_phase = 6'h3F, sample = 16'hFFFD; p = 8'hC0 -> table_phase = 6'h3F, sample = 16'h0003.
REQ-032 p = 8'h80 -> table_phase = 0, sample = 16'h7E6E; with SINE_SIGNED_OUT_EN -> sample = 16'hFE6E.
REQ-033 ACC_WIDTH = 24, phase_inc = 24'h040000, ticks every cycle -> p sequence 00,04,08,...,FC,00 (wrap); sample_valid high continuously.
REQ-034 phase_sync and tick in the same cycle with acc = 24'h123456, phase_inc = 24'h000100 -> sample from phase 0; acc = 24'h000100 afterwards.
REQ-035 rst_n pulsed low one cycle after a tick -> no sample_valid is produced; sample = 16'h8000.

Source files
------------

// File: rtl/quarter_wave_oscillator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// quarter_wave_oscillator
//
// A phase-accumulator (NCO) sine generator. It rebuilds a full sine wave from
// an external quarter-wave lookup table. The top 8 bits of the accumulator
// form the phase p:
//   - p[7:6] selects the quadrant.
//   - p[5:0] indexes the quarter-wave table. The index is mirrored in
//     quadrants 1 and 3.
//   - p[7] negates the table value (second half of the cycle).
//
// Pipeline, for each accepted tick:
//   cycle +1 : table_phase and the negate flag are presented from registers.
//   cycle +2 : sample is registered from table_data and sample_valid pulses.
//
// Ports:
//   clk          single clock; all state updates on its rising edge
//   rst_n        asynchronous, active-low reset
//   enable       when low, sample_tick is ignored and the accumulator holds
//   sample_tick  one-cycle strobe requesting one output sample
//   phase_inc    per-sample phase step (tuning word), unsigned, ACC_WIDTH bits
//   phase_sync   restart the phase at zero; honoured even while enable is low
//   table_phase  registered 6-bit address into the quarter-wave table
//   table_data   combinational table output for table_phase (offset binary,
//                positive half only)
//   sample       registered full-wave sample
//   sample_valid high for one cycle each time sample is updated
//
// Build option:
//   SINE_SIGNED_OUT_EN - when defined, sample is two's complement (the
//                        offset-binary value with its MSB inverted) and resets
//                        to 16'h0000. When it is not defined, sample is offset
//                        binary with midscale 16'h8000.
// -----------------------------------------------------------------------------
module quarter_wave_oscillator #(
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 sample_tick,
  input  logic [ACC_WIDTH-1:0] phase_inc,
  input  logic                 phase_sync,
  output logic [5:0]           table_phase,
  input  logic [15:0]          table_data,
  output logic [15:0]          sample,
  output logic                 sample_valid
);

`ifdef SINE_SIGNED_OUT_EN
  localparam logic [15:0] FORMAT_FLIP = 16'h8000;
`else
  localparam logic [15:0] FORMAT_FLIP = 16'h0000;
`endif
  // Midscale is the reset value in either output format.
  localparam logic [15:0] SAMPLE_RST = 16'h8000 ^ FORMAT_FLIP;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [5:0]           r_table_phase;
  logic                 r_negate;
  logic                 r_s1_valid;
  logic [15:0]          r_sample;
  logic                 r_sample_valid;

  logic                 w_accept;
  logic [7:0]           w_phase;
  logic [5:0]           w_addr;
  logic [15:0]          w_offset_bin;

  assign w_accept = enable & sample_tick;

  // The phase is taken from the accumulator before this cycle's update.
  // A sync request forces the sampled phase to zero.
  assign w_phase = phase_sync ? 8'h00 : r_acc[ACC_WIDTH-1 -: 8];

  // In quadrants 1 and 3 the waveform runs back down the table.
  assign w_addr = w_phase[6] ? ~w_phase[5:0] : w_phase[5:0];

  // The negative half-cycle is the two's-complement negation of the table
  // value. This mirrors the offset-binary code about midscale.
  assign w_offset_bin = r_negate ? (~table_data + 16'd1) : table_data;

  // Phase accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (phase_sync) begin
      r_acc <= w_accept ? phase_inc : '0;
    end else if (w_accept) begin
      r_acc <= r_acc + phase_inc;  // wraps silently modulo 2^ACC_WIDTH
    end
  end

  // Stage 1: table address and negate flag. These hold between ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_table_phase <= '0;
      r_negate      <= 1'b0;
      r_s1_valid    <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_table_phase <= w_addr;
        r_negate      <= w_phase[7];
      end
    end
  end

  // Stage 2: output sample. This stage does not depend on enable, so a
  // sample already in flight still completes after enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample       <= SAMPLE_RST;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sample <= w_offset_bin ^ FORMAT_FLIP;
      end
    end
  end

  assign table_phase  = r_table_phase;
  assign sample       = r_sample;
  assign sample_valid = r_sample_valid;

endmodule
